// File: rtl/noc_port_arbiter_if.sv
// Handshake bundle between requesters/downstream credit logic and the output-port arbiter.
// The master drives requests and credit returns. The slave (the arbiter) drives grants and status.
interface noc_port_arbiter_if #(
  parameter int NREQ = 5
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] tail;
  logic            credit_ret;
  logic [NREQ-1:0] gnt;
  logic [2:0]      owner;
  logic            busy;
  logic [2:0]      credit_cnt;
  logic            err;

  modport master (
    output req, tail, credit_ret,
    input  gnt, owner, busy, credit_cnt, err
  );

  modport slave (
    input  req, tail, credit_ret,
    output gnt, owner, busy, credit_cnt, err
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// Credit-based, packet-locked, round-robin arbiter for one NoC output port.
// An owner is chosen in IDLE. The port stays locked to that owner until its tail flit transfers.
module noc_port_arbiter #(
  parameter int NREQ    = 5,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  noc_port_arbiter_if.slave port_if
);
  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [2:0] LAST_RST = 3'(NREQ - 1);
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  state_e          state_q;
  logic [2:0]      owner_q;
  logic [2:0]      last_q;
  logic [2:0]      credit_q, credit_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] gnt_w;
  logic            credit_nz;
  logic            fire;
  logic            tail_own;
  logic            pick_vld;
  logic [2:0]      pick_idx;
  logic [2:0]      cand;

  assign credit_nz = (credit_q != 3'd0);

  // Grant is combinational on the owner's live request, so a bubble or credit stall costs no cycle.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
    localparam logic [2:0] IDX = 3'(gi);
    assign gnt_w[gi] = (state_q == BUSY) && (owner_q == IDX) && port_if.req[gi] && credit_nz;
  end

  assign fire     = |gnt_w;
  assign tail_own = port_if.tail[owner_q];

  // Scan from the farthest candidate back to last+1, so the nearest requester is written last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = 3'((int'(last_q) + k) % NREQ);
      if (port_if.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (fire && !port_if.credit_ret) begin
      credit_d = credit_q - 3'd1;
    end else if (!fire && port_if.credit_ret) begin
      if (credit_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= LAST_RST;
      credit_q <= CRED_MAX;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
      case (state_q)
        IDLE: begin
          if (pick_vld && credit_nz) begin
            owner_q <= pick_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (fire && tail_own) begin
            last_q  <= owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign port_if.gnt        = gnt_w;
  assign port_if.owner      = owner_q;
  assign port_if.busy       = (state_q == BUSY);
  assign port_if.credit_cnt = credit_q;
  assign port_if.err        = err_q;
endmodule

// File: tb/tb_noc_port_arbiter.sv
// Scoreboard bench for noc_port_arbiter: stimulus queues expected grants and status checks.
// The negedge monitor compares the DUT against those queued values.
module tb_noc_port_arbiter;
  localparam int SIG_BUSY = 0, SIG_OWNER = 1, SIG_CRED = 2, SIG_ERR = 3, SIG_GNT = 4;

  typedef struct {
    string name;
    int    sig;
    int    exp;
  } chk_t;

  logic clk;
  logic rst_n;
  logic done;
  int   nvec;
  int   nmis;

  logic [4:0] gq[$];
  chk_t       sq[$];

  noc_port_arbiter_if #(.NREQ(5)) ifc ();

  noc_port_arbiter #(.NREQ(5), .CREDITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .port_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_g(input int idx);
    logic [4:0] v;
    v = 5'd1 << idx;
    gq.push_back(v);
  endtask

  task automatic chk(input string n, input int s, input int e);
    chk_t c;
    c.name = n;
    c.sig  = s;
    c.exp  = e;
    sq.push_back(c);
  endtask

  function automatic int get_sig(input int s);
    case (s)
      SIG_BUSY:  return int'(ifc.busy);
      SIG_OWNER: return int'(ifc.owner);
      SIG_CRED:  return int'(ifc.credit_cnt);
      SIG_ERR:   return int'(ifc.err);
      default:   return int'(ifc.gnt);
    endcase
  endfunction

  // Monitor: the single owner of the scoreboard queues' pop side and of the counters.
  always @(negedge clk) begin
    logic [4:0] g;
    chk_t       c;
    int         act;
    if (ifc.gnt != 5'd0) begin
      nvec++;
      if (gq.size() == 0) begin
        nmis++;
        $display("FAIL unexpected_gnt got=%b want=none t=%0t", ifc.gnt, $time);
      end else begin
        g = gq.pop_front();
        if (ifc.gnt !== g) begin
          nmis++;
          $display("FAIL gnt_order got=%b want=%b t=%0t", ifc.gnt, g, $time);
        end else begin
          $display("grant gnt=%b owner=%0d credit=%0d t=%0t", ifc.gnt, ifc.owner, ifc.credit_cnt, $time);
        end
      end
    end
    while (sq.size() > 0) begin
      c   = sq.pop_front();
      act = get_sig(c.sig);
      nvec++;
      if (act != c.exp) begin
        nmis++;
        $display("FAIL %s got=%0d want=%0d t=%0t", c.name, act, c.exp, $time);
      end
    end
    if (done) begin
      nvec++;
      if (gq.size() != 0) begin
        nmis++;
        $display("FAIL missing_grants got=%0d_left want=0", gq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    nvec           = 0;
    nmis           = 0;
    done           = 1'b0;
    rst_n          = 1'b1;
    ifc.req        = 5'b0;
    ifc.tail       = 5'b0;
    ifc.credit_ret = 1'b0;
    #1 rst_n = 1'b0;
    chk("rst_busy", SIG_BUSY, 0);
    chk("rst_owner", SIG_OWNER, 0);
    chk("rst_credit", SIG_CRED, 4);
    chk("rst_err", SIG_ERR, 0);
    chk("rst_gnt", SIG_GNT, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // 3-flit packet from requester 2, then requester 4 wins the next round.
    ifc.req = 5'b10100;
    chk("arb_idle_busy", SIG_BUSY, 0);
    chk("arb_idle_gnt", SIG_GNT, 0);
    tick();
    chk("s1_busy", SIG_BUSY, 1);
    chk("s1_owner", SIG_OWNER, 2);
    chk("s1_credit4", SIG_CRED, 4);
    exp_g(2);
    tick();
    chk("s1_credit3", SIG_CRED, 3);
    exp_g(2);
    tick();
    ifc.tail = 5'b00100;
    chk("s1_credit2", SIG_CRED, 2);
    exp_g(2);
    tick();
    ifc.tail = 5'b0;
    chk("s1_tail_idle", SIG_BUSY, 0);
    chk("s1_credit1", SIG_CRED, 1);
    chk("s1_idle_gnt", SIG_GNT, 0);
    tick();
    chk("s1_next_owner", SIG_OWNER, 4);
    chk("s1_next_busy", SIG_BUSY, 1);
    ifc.req  = 5'b10000;
    ifc.tail = 5'b10000;
    exp_g(4);
    tick();
    ifc.req  = 5'b0;
    ifc.tail = 5'b0;
    chk("s1_credit0", SIG_CRED, 0);
    chk("s1_done_idle", SIG_BUSY, 0);
    ifc.credit_ret = 1'b1;
    repeat (4) tick();
    ifc.credit_ret = 1'b0;
    chk("s1_refill", SIG_CRED, 4);

    // Five single-flit requesters, credit returned alongside each fire.
    ifc.req  = 5'b11111;
    ifc.tail = 5'b11111;
    foreach (gq[i]) begin end
    for (int n = 0; n < 6; n++) begin
      ifc.credit_ret = 1'b0;
      tick();
      ifc.credit_ret = 1'b1;
      exp_g(n % 5);
      chk("rr_owner", SIG_OWNER, n % 5);
      chk("rr_credit", SIG_CRED, 4);
      tick();
    end
    ifc.req        = 5'b0;
    ifc.tail       = 5'b0;
    ifc.credit_ret = 1'b0;
    chk("rr_credit_end", SIG_CRED, 4);
    chk("rr_err", SIG_ERR, 0);

    // 6-flit packet from requester 3 with only 4 credits available.
    ifc.req = 5'b01000;
    tick();
    chk("cr_owner", SIG_OWNER, 3);
    for (int n = 0; n < 4; n++) begin
      exp_g(3);
      chk("cr_credit_dec", SIG_CRED, 4 - n);
      tick();
    end
    for (int n = 0; n < 2; n++) begin
      chk("cr_stall_gnt", SIG_GNT, 0);
      chk("cr_stall_busy", SIG_BUSY, 1);
      chk("cr_stall_credit", SIG_CRED, 0);
      tick();
    end
    ifc.credit_ret = 1'b1;
    chk("cr_ret_gnt", SIG_GNT, 0);
    tick();
    ifc.credit_ret = 1'b0;
    chk("cr_one_credit", SIG_CRED, 1);
    exp_g(3);
    tick();
    chk("cr_after_one_gnt", SIG_GNT, 0);
    chk("cr_after_one_busy", SIG_BUSY, 1);
    ifc.credit_ret = 1'b1;
    ifc.tail       = 5'b01000;
    tick();
    ifc.credit_ret = 1'b0;
    exp_g(3);
    tick();
    ifc.req  = 5'b0;
    ifc.tail = 5'b0;
    chk("cr_done_idle", SIG_BUSY, 0);
    ifc.credit_ret = 1'b1;
    repeat (4) tick();
    ifc.credit_ret = 1'b0;
    chk("cr_refill", SIG_CRED, 4);

    // Owner 4 bubbles for 2 cycles while requester 1 waits.
    ifc.req = 5'b10000;
    tick();
    chk("bb_owner", SIG_OWNER, 4);
    exp_g(4);
    tick();
    ifc.req = 5'b00010;
    for (int n = 0; n < 2; n++) begin
      chk("bb_gnt", SIG_GNT, 0);
      chk("bb_owner_hold", SIG_OWNER, 4);
      chk("bb_busy", SIG_BUSY, 1);
      tick();
    end
    ifc.req = 5'b10010;
    exp_g(4);
    tick();
    ifc.tail = 5'b10000;
    exp_g(4);
    tick();
    ifc.req  = 5'b0;
    ifc.tail = 5'b0;
    chk("bb_idle", SIG_BUSY, 0);
    chk("bb_credit", SIG_CRED, 1);
    ifc.credit_ret = 1'b1;
    repeat (3) tick();
    ifc.credit_ret = 1'b0;

    // Credit return at full credit is an overflow and the flag sticks.
    chk("ov_pre_err", SIG_ERR, 0);
    ifc.credit_ret = 1'b1;
    tick();
    ifc.credit_ret = 1'b0;
    chk("ov_credit", SIG_CRED, 4);
    chk("ov_err", SIG_ERR, 1);
    repeat (10) tick();
    chk("ov_err_sticky", SIG_ERR, 1);

    // Reset mid-packet from requester 2.
    ifc.req = 5'b00100;
    tick();
    chk("mr_owner", SIG_OWNER, 2);
    exp_g(2);
    tick();
    exp_g(2);
    tick();
    rst_n = 1'b0;
    chk("mr_gnt", SIG_GNT, 0);
    chk("mr_busy", SIG_BUSY, 0);
    chk("mr_credit", SIG_CRED, 4);
    chk("mr_err", SIG_ERR, 0);
    chk("mr_owner_rst", SIG_OWNER, 0);
    tick();
    rst_n    = 1'b1;
    ifc.req  = 5'b00101;
    ifc.tail = 5'b00001;
    tick();
    chk("mr_prio0_owner", SIG_OWNER, 0);
    chk("mr_prio0_busy", SIG_BUSY, 1);
    exp_g(0);
    tick();
    ifc.req  = 5'b0;
    ifc.tail = 5'b0;
    chk("mr_done_idle", SIG_BUSY, 0);
    chk("mr_credit_after", SIG_CRED, 3);
    tick();
    done = 1'b1;
  end
endmodule

// File: doc/noc_port_arbiter.md
NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 5, giving the number of requesters, indexed 0=N, 1=S, 2=E, 3=W, 4=L.
REQ-002 The block SHALL have parameter CREDITS, default 4, giving the downstream buffer depth in flits (legal range 1..7).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port req, input, NREQ bits: requester i holds a head flit.
REQ-006 The block SHALL have port tail, input, NREQ bits: requester i's head flit is the last flit of its packet (sampled only when fire).
REQ-007 The block SHALL have port credit_ret, input, 1 bit: one-cycle pulse, downstream has freed one buffer slot.
REQ-008 The block SHALL have port gnt, output, NREQ bits: one-hot or zero; requester i's flit transfers this cycle.
REQ-009 The block SHALL have port owner, output, 3 bits: index of the requester holding the output port.
REQ-010 The block SHALL have port busy, output, 1 bit: the port is locked to owner (state BUSY).
REQ-011 The block SHALL have port credit_cnt, output, 3 bits: available downstream credits.
REQ-012 The block SHALL have port err, output, 1 bit: sticky credit-overflow flag.

Function
REQ-013 The state machine SHALL have exactly two states: IDLE and BUSY.
REQ-014 In IDLE, when any req bit is set and credit_cnt>0, the block SHALL select the first set req bit in round-robin order starting at last+1 mod NREQ, register it into owner, and enter BUSY on the next edge.
- gnt SHALL be 0 in IDLE.
- Arbitration latency: 1 cycle from req to busy.
REQ-015 In IDLE with credit_cnt=0, the block SHALL remain in IDLE regardless of req.
REQ-016 In BUSY, gnt SHALL be combinational: gnt[owner] = req[owner] and (credit_cnt>0); all other bits SHALL be 0.
- fire = |gnt.
REQ-017 On fire with tail[owner]=1, the block SHALL load last<=owner and return to IDLE on the next edge.
- The first grant to another requester is therefore no earlier than 2 cycles after the tail flit.
REQ-018 In BUSY, the block SHALL hold owner while req[owner] is low (bubble) and SHALL NOT re-arbitrate mid-packet.
REQ-019 credit_cnt behaviour:
- fire alone: credit_cnt SHALL decrement by 1.
- credit_ret alone: credit_cnt SHALL increment by 1.
- fire and credit_ret together: credit_cnt SHALL be unchanged.
REQ-020 credit_ret with no fire while credit_cnt=CREDITS SHALL leave credit_cnt at CREDITS and set err; err SHALL stay set until reset.
REQ-021 fire SHALL be impossible at credit_cnt=0, so credit_cnt SHALL never underflow.
REQ-022 req bits for indices not equal to owner SHALL have no effect while in BUSY.

Reset
REQ-023 While rst_n=0, the block SHALL immediately force state=IDLE, owner=0, busy=0, gnt=0, credit_cnt=CREDITS, err=0, and last=NREQ-1, so that index 0 has first priority.
REQ-024 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from the reset values without any stale grant.

Verification
REQ-025 The bench SHALL cover: reset, then req=5'b10100 held -> busy=1 with owner=2 after 1 cycle; a 3-flit packet (tail on the 3rd fire) -> gnt=5'b00100 for 3 cycles, credit_cnt 4->1, then IDLE, then owner=4.
REQ-026 The bench SHALL cover: all 5 requesting single-flit packets with continuous credit_ret -> grant order 0,1,2,3,4,0 with credit_cnt stable.
REQ-027 The bench SHALL cover: CREDITS=4, no credit_ret, 6-flit packet -> 4 fires, then gnt=0 with busy=1; one credit_ret -> exactly one more fire.
REQ-028 The bench SHALL cover: credit_ret while credit_cnt=4 and idle -> credit_cnt=4 and err=1 next cycle, err still 1 ten cycles later.
REQ-029 The bench SHALL cover: req[owner] dropping for 2 cycles mid-packet while req[1] is high -> owner unchanged, gnt=0 for those cycles, packet resumes.
REQ-030 The bench SHALL cover: rst_n pulsed low mid-packet -> gnt=0 immediately, credit_cnt=4, and next arbitration favours index 0.
